// File: rtl/latency_measure.sv
`timescale 1ns/1ps
// Round-trip latency probe: fires 2^RUNS_LOG2 tx strobes after a quiet gap on rx,
// times each rx rising edge in cycles and publishes the truncated average on lat.
module latency_measure #(
    parameter int LSIZE     = 10,
    parameter int RUNS_LOG2 = 2,
    parameter int GAP       = 4,
    parameter int LAT_INIT  = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rx,
    output logic             tx,
    output logic [LSIZE-1:0] lat,
    output logic             lat_valid,
    output logic             busy,
    output logic             err
);

    localparam int ACC_W  = LSIZE + RUNS_LOG2;
    localparam int RIDX_W = RUNS_LOG2 + 1;

    // Counters give up one step short of all-ones, so a saturated count never becomes a sample.
    localparam logic [LSIZE-1:0]  CNT_LIMIT = {{(LSIZE-1){1'b1}}, 1'b0};
    localparam logic [LSIZE-1:0]  GAP_LAST  = LSIZE'(GAP - 1);
    localparam logic [RIDX_W-1:0] RUN_LAST  = RIDX_W'((1 << RUNS_LOG2) - 1);
    localparam logic [LSIZE-1:0]  LAT_RST   = LSIZE'(LAT_INIT);
    localparam logic [LSIZE-1:0]  LAT_MIN   = LSIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIET,
        S_FIRE,
        S_WAIT,
        S_ACC,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_reg;
    logic               rx_reg;
    logic [LSIZE-1:0]   quiet_cnt_reg;
    logic [LSIZE-1:0]   cyc_cnt_reg;
    logic [LSIZE-1:0]   sample_reg;
    logic [RIDX_W-1:0]  run_idx_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               tx_reg;
    logic [LSIZE-1:0]   lat_reg;
    logic               lat_valid_reg;
    logic               busy_reg;
    logic               err_reg;

    logic               rx_rise;
    logic [ACC_W-1:0]   acc_sum;
    logic [LSIZE-1:0]   avg;
    logic [LSIZE-1:0]   avg_clamped;

    assign rx_rise     = rx & ~rx_reg;
    assign acc_sum     = acc_reg + ACC_W'(sample_reg);
    assign avg         = acc_sum[ACC_W-1:RUNS_LOG2];
    assign avg_clamped = (avg == '0) ? LAT_MIN : avg;

    assign tx        = tx_reg;
    assign lat       = lat_reg;
    assign lat_valid = lat_valid_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rx_reg        <= 1'b0;
            quiet_cnt_reg <= '0;
            cyc_cnt_reg   <= '0;
            sample_reg    <= '0;
            run_idx_reg   <= '0;
            acc_reg       <= '0;
            tx_reg        <= 1'b0;
            lat_reg       <= LAT_RST;
            lat_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            rx_reg        <= rx;
            tx_reg        <= 1'b0;
            lat_valid_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_QUIET;
                        run_idx_reg   <= '0;
                        acc_reg       <= '0;
                        quiet_cnt_reg <= '0;
                        cyc_cnt_reg   <= '0;
                        err_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end

                // cyc_cnt doubles as the quiet-phase timeout; it is never reset by rx activity.
                S_QUIET: begin
                    if (!rx && quiet_cnt_reg == GAP_LAST) begin
                        state_reg   <= S_FIRE;
                        tx_reg      <= 1'b1;
                        cyc_cnt_reg <= '0;
                    end else if (cyc_cnt_reg == CNT_LIMIT) begin
                        state_reg <= S_ERR;
                        err_reg   <= 1'b1;
                    end else begin
                        quiet_cnt_reg <= rx ? '0 : quiet_cnt_reg + 1'b1;
                        cyc_cnt_reg   <= cyc_cnt_reg + 1'b1;
                    end
                end

                S_FIRE: begin
                    state_reg   <= S_WAIT;
                    cyc_cnt_reg <= LSIZE'(1);
                end

                S_WAIT: begin
                    if (rx_rise) begin
                        sample_reg <= cyc_cnt_reg;
                        state_reg  <= S_ACC;
                    end else if (cyc_cnt_reg == CNT_LIMIT) begin
                        state_reg <= S_ERR;
                        err_reg   <= 1'b1;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end

                // lat and lat_valid are loaded here so both appear together in the DONE cycle.
                S_ACC: begin
                    acc_reg     <= acc_sum;
                    run_idx_reg <= run_idx_reg + 1'b1;
                    if (run_idx_reg == RUN_LAST) begin
                        state_reg     <= S_DONE;
                        lat_reg       <= avg_clamped;
                        lat_valid_reg <= 1'b1;
                    end else begin
                        state_reg     <= S_QUIET;
                        quiet_cnt_reg <= '0;
                        cyc_cnt_reg   <= '0;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                S_ERR: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latency_measure.sv
`timescale 1ns/1ps
// Scoreboard bench for latency_measure: an echo model answers each tx after k cycles,
// and a monitor checks every lat_valid / err event against queued expectations.
module tb_latency_measure;

    localparam int LSIZE     = 10;
    localparam int RUNS_LOG2 = 2;
    localparam int GAP       = 4;
    localparam int LAT_INIT  = 1;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             rx;
    logic             rx_force = 1'b0;
    logic             echo_rx  = 1'b0;
    logic             tx;
    logic [LSIZE-1:0] lat;
    logic             lat_valid;
    logic             busy;
    logic             err;

    assign rx = rx_force | echo_rx;

    latency_measure #(
        .LSIZE     (LSIZE),
        .RUNS_LOG2 (RUNS_LOG2),
        .GAP       (GAP),
        .LAT_INIT  (LAT_INIT)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .rx        (rx),
        .tx        (tx),
        .lat       (lat),
        .lat_valid (lat_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit    is_err;
        int    lat;
        int    ref_kind;   // 0: no timing check, 1: relative to last tx, 2: relative to start
        int    delta;
        string name;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  e;
    int    echo_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cycle = 0;
    int    tx_count = 0;
    int    valid_count = 0;
    int    last_tx_cycle = 0;
    int    start_cycle = 0;
    int    low_run = 0;
    logic  err_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) cycle <= cycle + 1;

    // Consecutive rx-low samples as seen by the DUT on its active edge.
    always @(posedge clock) begin
        if (!rst_n) low_run = 0;
        else        low_run = rx ? 0 : low_run + 1;
    end

    // Monitor: outputs sampled on the falling edge.
    always @(negedge clock) begin
        if (rst_n) begin
            if (tx) begin
                tx_count++;
                last_tx_cycle = cycle;
                $display("[TB] tx #%0d at cycle %0d (quiet run %0d)", tx_count, cycle, low_run);
                check("quiet_gap_before_tx", int'(low_run >= GAP), 1);
            end
            if (lat_valid) begin
                valid_count++;
                $display("[TB] lat_valid at cycle %0d lat=%0d", cycle, lat);
                check("sb_entry_for_valid", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({e.name, "_lat"}, int'(lat), e.lat);
                    check({e.name, "_kind"}, int'(err), int'(e.is_err));
                end
            end
            if (err && !err_prev) begin
                $display("[TB] err rose at cycle %0d lat=%0d", cycle, lat);
                check("sb_entry_for_err", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({e.name, "_kind"}, int'(err), int'(e.is_err));
                    check({e.name, "_lat_kept"}, int'(lat), e.lat);
                    if (e.ref_kind == 1)
                        check({e.name, "_err_delay"}, cycle - last_tx_cycle, e.delta);
                    else if (e.ref_kind == 2)
                        check({e.name, "_err_delay"}, cycle - start_cycle, e.delta);
                end
            end
        end
        err_prev = err;
    end

    // Echo model: raise rx during WAIT cycle k after each tx.
    initial begin
        int k;
        forever begin
            @(negedge clock);
            if (rst_n && tx) begin
                k = (echo_q.size() > 0) ? echo_q.pop_front() : -1;
                if (k > 0) begin
                    repeat (k) @(negedge clock);
                    echo_rx = 1'b1;
                    repeat (2) @(negedge clock);
                    echo_rx = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start(input bit record);
        @(negedge clock);
        start = 1'b1;
        if (record) begin
            start_cycle = cycle;
            $display("[TB] start at cycle %0d", cycle);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_finished_in_time"}, int'(busy), 0);
    endtask

    task automatic measure(input string name, input int k0, input int k1, input int k2,
                           input int k3, input int exp_lat, input bit extra_starts);
        int tx0 = tx_count;
        int v0  = valid_count;
        exp_t x;
        echo_q = {k0, k1, k2, k3};
        x.is_err = 1'b0; x.lat = exp_lat; x.ref_kind = 0; x.delta = 0; x.name = name;
        sb_q.push_back(x);
        pulse_start(1'b1);
        check({name, "_err_cleared"}, int'(err), 0);
        if (extra_starts) begin
            for (int i = 0; i < 3; i++) begin
                repeat (3) @(negedge clock);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        end
        wait_idle(name, 3000);
        repeat (4) @(negedge clock);
        check({name, "_tx_pulses"}, tx_count - tx0, 4);
        check({name, "_valid_pulses"}, valid_count - v0, 1);
        check({name, "_lat_held"}, int'(lat), exp_lat);
        check({name, "_err_low"}, int'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0;
        int v0;
        int n;
        exp_t x;

        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_tx", int'(tx), 0);
        check("reset_lat", int'(lat), LAT_INIT);
        check("reset_lat_valid", int'(lat_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clock);

        measure("echo_k7", 7, 7, 7, 7, 7, 1'b0);
        measure("echo_mixed", 5, 6, 6, 8, 6, 1'b0);
        measure("echo_k1_restart", 1, 1, 1, 1, 1, 1'b1);

        // rx stuck high: quiet gap never satisfied
        rx_force = 1'b1;
        repeat (3) @(negedge clock);
        tx0 = tx_count; v0 = valid_count;
        x.is_err = 1'b1; x.lat = 1; x.ref_kind = 2; x.delta = 1024; x.name = "quiet_timeout";
        sb_q.push_back(x);
        pulse_start(1'b1);
        wait_idle("quiet_timeout", 1200);
        check("quiet_timeout_no_tx", tx_count - tx0, 0);
        check("quiet_timeout_no_valid", valid_count - v0, 0);
        repeat (10) @(negedge clock);
        check("quiet_timeout_err_sticky", int'(err), 1);
        check("quiet_timeout_lat", int'(lat), 1);
        rx_force = 1'b0;
        repeat (5) @(negedge clock);

        measure("echo_k3", 3, 3, 3, 3, 3, 1'b0);

        // third echo missing: WAIT timeout
        tx0 = tx_count; v0 = valid_count;
        echo_q = {5, 5, -1};
        x.is_err = 1'b1; x.lat = 3; x.ref_kind = 1; x.delta = 1023; x.name = "wait_timeout";
        sb_q.push_back(x);
        pulse_start(1'b1);
        wait_idle("wait_timeout", 2000);
        repeat (5) @(negedge clock);
        check("wait_timeout_tx_pulses", tx_count - tx0, 3);
        check("wait_timeout_no_valid", valid_count - v0, 0);
        check("wait_timeout_err", int'(err), 1);
        check("wait_timeout_lat", int'(lat), 3);

        // reset during the second WAIT
        tx0 = tx_count; v0 = valid_count;
        echo_q = {9, -1};
        pulse_start(1'b1);
        n = 0;
        while (tx_count < tx0 + 2 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("abort_second_tx_seen", tx_count - tx0, 2);
        repeat (5) @(negedge clock);
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_reset_lat", int'(lat), LAT_INIT);
        check("abort_reset_busy", int'(busy), 0);
        check("abort_reset_err", int'(err), 0);
        rst_n = 1'b1;
        echo_q = {};
        repeat (20) @(negedge clock);
        check("abort_no_tx_without_start", tx_count - tx0, 2);
        check("abort_no_valid", valid_count - v0, 0);
        check("abort_idle_busy", int'(busy), 0);

        measure("after_reset_k9", 9, 9, 9, 9, 9, 1'b0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
